// File: rtl/branch_flag_unit.sv
// branch_flag_unit: architectural flag register, branch resolution, program
// counter and return-address stack for the single-cycle KGPRISC datapath.
// Optional build macro: BRANCH_FLAG_FWD_EN -- branches evaluate forwarded
// flags (this cycle's ALU flags merged under flag_we) instead of flags_q.
// br_valid is a plain qualifier: there is no backpressure, a branch presented
// with br_valid=1 and stall=0 is consumed on that rising edge.
module branch_flag_unit #(
    parameter int              PC_W      = 32,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [3:0]      flag_we,
    input  logic            carry_in,
    input  logic            zero_in,
    input  logic            ovf_in,
    input  logic            sign_in,
    input  logic            br_valid,
    input  logic [3:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] reg_target,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      flags_q,
    output logic            taken,
    output logic            ras_ovf,
    output logic            ras_unf
);

    localparam int             AW       = $clog2(RAS_DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(RAS_DEPTH);

    // Branch opcodes
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_BZ   = 4'b0001;
    localparam logic [3:0] OP_BNZ  = 4'b0010;
    localparam logic [3:0] OP_BCY  = 4'b0011;
    localparam logic [3:0] OP_BNCY = 4'b0100;
    localparam logic [3:0] OP_BO   = 4'b0101;
    localparam logic [3:0] OP_BNO  = 4'b0110;
    localparam logic [3:0] OP_BLTZ = 4'b0111;
    localparam logic [3:0] OP_CALL = 4'b1000;
    localparam logic [3:0] OP_RET  = 4'b1001;
    localparam logic [3:0] OP_JR   = 4'b1010;

    logic [PC_W-1:0] ras_mem [RAS_DEPTH];
    logic [AW-1:0]   ras_ptr;
    logic [AW-1:0]   ras_ptr_m1;
    logic [AW:0]     ras_cnt;
    logic            ras_full;
    logic            ras_empty;

    logic [3:0]      flags_new;
    logic [3:0]      flags_merged;
    logic [3:0]      flags_eval;
    logic            ev_c, ev_z, ev_v, ev_s;

    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_next;
    logic            taken_next;
    logic            push;
    logic            pop;
    logic            ovf_set;
    logic            unf_set;

    // Flag vector ordering is {C,Z,V,S}, matching flag_we bit positions.
    assign flags_new    = {carry_in, zero_in, ovf_in, sign_in};
    assign flags_merged = (flag_we & flags_new) | (~flag_we & flags_q);

`ifdef BRANCH_FLAG_FWD_EN
    assign flags_eval = flags_merged;
`else
    assign flags_eval = flags_q;
`endif

    assign ev_c = flags_eval[3];
    assign ev_z = flags_eval[2];
    assign ev_v = flags_eval[1];
    assign ev_s = flags_eval[0];

    assign pc_seq     = pc + PC_W'(4);
    assign ras_ptr_m1 = ras_ptr - AW'(1);
    assign ras_full   = (ras_cnt == FULL_CNT);
    assign ras_empty  = (ras_cnt == '0);

    // Resolve the branch in execute into next PC, redirect flag and RAS op.
    always_comb begin
        pc_next    = pc_seq;
        taken_next = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (br_valid) begin
            case (br_cond)
                OP_BR: begin
                    pc_next    = br_target;
                    taken_next = 1'b1;
                end
                OP_BZ, OP_BNZ, OP_BCY, OP_BNCY, OP_BO, OP_BNO, OP_BLTZ: begin
                    if ((br_cond == OP_BZ   &&  ev_z) ||
                        (br_cond == OP_BNZ  && !ev_z) ||
                        (br_cond == OP_BCY  &&  ev_c) ||
                        (br_cond == OP_BNCY && !ev_c) ||
                        (br_cond == OP_BO   &&  ev_v) ||
                        (br_cond == OP_BNO  && !ev_v) ||
                        (br_cond == OP_BLTZ &&  ev_s)) begin
                        pc_next    = br_target;
                        taken_next = 1'b1;
                    end
                end
                OP_CALL: begin
                    push       = 1'b1;
                    ovf_set    = ras_full;
                    pc_next    = br_target;
                    taken_next = 1'b1;
                end
                OP_RET: begin
                    // Underflow falls through sequentially and leaves the stack alone.
                    if (ras_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        pop        = 1'b1;
                        pc_next    = ras_mem[ras_ptr_m1];
                        taken_next = 1'b1;
                    end
                end
                OP_JR: begin
                    pc_next    = reg_target;
                    taken_next = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Architectural state: PC, flags, redirect pulse, RAS pointers, sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            flags_q <= '0;
            taken   <= 1'b0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (stall) begin
            taken <= 1'b0;
        end else begin
            pc      <= pc_next;
            taken   <= taken_next;
            flags_q <= flags_merged;
            if (ovf_set) ras_ovf <= 1'b1;
            if (unf_set) ras_unf <= 1'b1;
            if (push) begin
                ras_ptr <= ras_ptr + AW'(1);
                // A push onto a full stack overwrites the oldest entry.
                if (!ras_full) ras_cnt <= ras_cnt + (AW+1)'(1);
            end else if (pop) begin
                ras_ptr <= ras_ptr_m1;
                ras_cnt <= ras_cnt - (AW+1)'(1);
            end
        end
    end

    // Return-address storage; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (!rst && !stall && push) begin
            ras_mem[ras_ptr] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Testbench for branch_flag_unit: directed plan steps followed by random
// traffic, each cycle checked against a queue-based reference model.
module tb_branch_flag_unit;

    localparam int          PC_W      = 32;
    localparam int          RAS_DEPTH = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [3:0]  flag_we;
    logic        carry_in, zero_in, ovf_in, sign_in;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic [31:0] br_target;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [3:0]  flags_q;
    logic        taken;
    logic        ras_ovf;
    logic        ras_unf;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [3:0]  m_flags;
    logic        m_taken;
    logic        m_ovf;
    logic        m_unf;
    logic [31:0] ras_q[$];

    branch_flag_unit #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flag_we    (flag_we),
        .carry_in   (carry_in),
        .zero_in    (zero_in),
        .ovf_in     (ovf_in),
        .sign_in    (sign_in),
        .br_valid   (br_valid),
        .br_cond    (br_cond),
        .br_target  (br_target),
        .reg_target (reg_target),
        .pc         (pc),
        .flags_q    (flags_q),
        .taken      (taken),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: one architectural cycle, RAS kept as a bounded list.
    task automatic model_cycle(input logic r, input logic s, input logic [3:0] we,
                               input logic [3:0] fl, input logic bv, input logic [3:0] cond,
                               input logic [31:0] tgt, input logic [31:0] rtgt);
        logic [3:0]  merged;
        logic [3:0]  ev;
        logic [31:0] next_pc;
        logic        tk;
        logic        take_cond;
        if (r) begin
            m_pc = RESET_PC; m_flags = 4'h0; m_taken = 1'b0;
            m_ovf = 1'b0; m_unf = 1'b0; ras_q.delete();
        end else if (s) begin
            m_taken = 1'b0;
        end else begin
            merged = 4'h0;
            for (int i = 0; i < 4; i++) merged[i] = we[i] ? fl[i] : m_flags[i];
`ifdef BRANCH_FLAG_FWD_EN
            ev = merged;
`else
            ev = m_flags;
`endif
            next_pc = m_pc + 32'd4;
            tk = 1'b0;
            take_cond = 1'b0;
            if (bv) begin
                if (cond >= 4'd1 && cond <= 4'd7) begin
                    case (cond)
                        4'd1: take_cond = ev[2];
                        4'd2: take_cond = !ev[2];
                        4'd3: take_cond = ev[3];
                        4'd4: take_cond = !ev[3];
                        4'd5: take_cond = ev[1];
                        4'd6: take_cond = !ev[1];
                        default: take_cond = ev[0];
                    endcase
                    if (take_cond) begin next_pc = tgt; tk = 1'b1; end
                end else if (cond == 4'd0) begin
                    next_pc = tgt; tk = 1'b1;
                end else if (cond == 4'd8) begin
                    ras_q.push_back(m_pc + 32'd4);
                    if (ras_q.size() > RAS_DEPTH) begin
                        void'(ras_q.pop_front());
                        m_ovf = 1'b1;
                    end
                    next_pc = tgt; tk = 1'b1;
                end else if (cond == 4'd9) begin
                    if (ras_q.size() == 0) m_unf = 1'b1;
                    else begin next_pc = ras_q.pop_back(); tk = 1'b1; end
                end else if (cond == 4'd10) begin
                    next_pc = rtgt; tk = 1'b1;
                end
            end
            m_flags = merged;
            m_pc    = next_pc;
            m_taken = tk;
        end
    endtask

    // Driver: apply one cycle of inputs, advance model, check all outputs.
    task automatic step(input string tag, input logic r, input logic s, input logic [3:0] we,
                        input logic [3:0] fl, input logic bv, input logic [3:0] cond,
                        input logic [31:0] tgt, input logic [31:0] rtgt);
        rst = r; stall = s; flag_we = we;
        carry_in = fl[3]; zero_in = fl[2]; ovf_in = fl[1]; sign_in = fl[0];
        br_valid = bv; br_cond = cond; br_target = tgt; reg_target = rtgt;
        @(posedge clk);
        #1;
        model_cycle(r, s, we, fl, bv, cond, tgt, rtgt);
        check({tag, ".pc"},      pc,              m_pc);
        check({tag, ".flags"},   {28'h0, flags_q}, {28'h0, m_flags});
        check({tag, ".taken"},   {31'h0, taken},   {31'h0, m_taken});
        check({tag, ".ras_ovf"}, {31'h0, ras_ovf}, {31'h0, m_ovf});
        check({tag, ".ras_unf"}, {31'h0, ras_unf}, {31'h0, m_unf});
    endtask

    task automatic plain(input string tag);
        step(tag, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic branch(input string tag, input logic [3:0] cond, input logic [31:0] tgt);
        step(tag, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, cond, tgt, 32'h0);
    endtask

    // Stimulus and final report
    initial begin
        rst = 1'b1; stall = 1'b0; flag_we = 4'h0;
        carry_in = 1'b0; zero_in = 1'b0; ovf_in = 1'b0; sign_in = 1'b0;
        br_valid = 1'b0; br_cond = 4'h0; br_target = 32'h0; reg_target = 32'h0;
        m_pc = RESET_PC; m_flags = 4'h0; m_taken = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset for two cycles (second one with stall and a branch pending), then run
        step("rst0", 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        step("rst1", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 32'h1234, 32'h0);
        check("rst.pc_const", pc, 32'h0);
        plain("run1");
        plain("run2");
        plain("run3");
        check("run.pc12", pc, 32'd12);

        // Per-flag mask, then bz taken and bnz not taken
        step("mask", 1'b0, 1'b0, 4'b0100, 4'b1111, 1'b0, 4'h0, 32'h0, 32'h0);
        check("mask.flags_const", {28'h0, flags_q}, 32'h4);
        branch("bz40", 4'b0001, 32'h40);
        check("bz40.pc_const", pc, 32'h40);
        branch("bnz", 4'b0010, 32'h900);
        check("bnz.pc_const", pc, 32'h44);

        // Same-cycle flag write and branch
        step("clr", 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        step("fwd", 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0001, 32'h80, 32'h0);

        // RAS fill: five calls, five returns
        branch("to100", 4'b0000, 32'h100);
        branch("call1", 4'b1000, 32'h200);
        branch("call2", 4'b1000, 32'h300);
        branch("call3", 4'b1000, 32'h400);
        branch("call4", 4'b1000, 32'h500);
        branch("call5", 4'b1000, 32'h600);
        check("call5.ovf_const", {31'h0, ras_ovf}, 32'h1);
        branch("ret1", 4'b1001, 32'h0);
        check("ret1.pc_const", pc, 32'h504);
        branch("ret2", 4'b1001, 32'h0);
        branch("ret3", 4'b1001, 32'h0);
        branch("ret4", 4'b1001, 32'h0);
        check("ret4.pc_const", pc, 32'h204);
        branch("ret5", 4'b1001, 32'h0);
        check("ret5.pc_const", pc, 32'h208);

        // Stall holds everything, then jr and PC wrap
        step("stall", 1'b0, 1'b1, 4'hF, 4'hA, 1'b1, 4'h0, 32'h777, 32'h0);
        step("jr", 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'b1010, 32'h0, 32'hFFFF_FFFC);
        plain("wrap");
        check("wrap.pc_const", pc, 32'h0);

        // Mid-call reset
        branch("to20", 4'b0000, 32'h20);
        branch("call24", 4'b1000, 32'h300);
        step("midrst", 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'b1000, 32'h500, 32'h0);
        branch("ret_empty", 4'b1001, 32'h0);
        check("ret_empty.unf_const", {31'h0, ras_unf}, 32'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        r, s, bv;
            logic [3:0]  we, fl, cond;
            logic [31:0] tgt, rtgt;
            r    = ($urandom_range(0, 39) == 0);
            s    = ($urandom_range(0, 7) == 0);
            we   = 4'($urandom_range(0, 15));
            fl   = 4'($urandom_range(0, 15));
            bv   = ($urandom_range(0, 1) == 1);
            cond = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 10))
                                               : 4'($urandom_range(0, 15));
            tgt  = $urandom() & 32'hFFFF_FFFC;
            rtgt = $urandom();
            step("rand", r, s, we, fl, bv, cond, tgt, rtgt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
